// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; a 1-bit floor keeps narrow instances legal.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Parallel operand/result handshake bundle for the serial adder sequencer.
interface serial_add_sequencer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

endinterface

// File: rtl/serial_add_bit_cell.sv
// One-bit full adder with a registered carry, stepped once per enabled edge.
module serial_add_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  logic carry_q;
  logic half_c;

  assign half_c = a ^ b;
  assign sum    = half_c ^ carry_q;
  assign carry  = (a & b) | (carry_q & half_c);

  // clear wins over en so a fresh operation always starts with carry-in 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (clear) begin
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= carry;
    end
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Wraps the serial bit cell behind parallel valid/ready: LSB-first over WIDTH cycles.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_add_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             carry_out_q;

  logic             cell_clear_c;
  logic             cell_en_c;
  logic             bit_sum_c;
  logic             bit_carry_c;
  logic             inc_carry_c;

  // Bit cell control is decoded from the current state and input handshake.
  always_comb begin
    cell_clear_c = 1'b0;
    cell_en_c    = 1'b0;
    if (state_q == IDLE) begin
      cell_clear_c = bus.in_valid;
    end
    if (state_q == RUN) begin
      cell_en_c = 1'b1;
    end
  end

  // Ripple incrementer for the bit counter built from XOR/AND only.
  always_comb begin
    cnt_d       = '0;
    inc_carry_c = 1'b1;
    for (int i = 0; i < CNT_W; i++) begin
      cnt_d[i]    = cnt_q[i] ^ inc_carry_c;
      inc_carry_c = inc_carry_c & cnt_q[i];
    end
  end

  serial_add_bit_cell u_bit_cell (
    .clk   (clk),
    .rst   (rst),
    .clear (cell_clear_c),
    .en    (cell_en_c),
    .a     (a_q[0]),
    .b     (b_q[0]),
    .sum   (bit_sum_c),
    .carry (bit_carry_c)
  );

  // Sequencer FSM; sum and carry_out only move in RUN and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q <= {bit_sum_c, sum_q[WIDTH-1:1]};
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          cnt_q <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            carry_out_q <= bit_carry_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a result scoreboard.
module tb_serial_add_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LIMIT = 50;

  typedef struct packed {
    logic             c;
    logic [WIDTH-1:0] s;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   accept_cyc;
  exp_t sb[$];

  serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Drive one operand pair, wait for the accept edge and record the expected result.
  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit keep);
    int n;
    logic [WIDTH:0] full;
    n = 0;
    while (!bus.in_ready && n < LIMIT) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    tick();
    accept_cyc = cyc;
    full = {1'b0, a} + {1'b0, b};
    sb.push_back(exp_t'{c: full[WIDTH], s: full[WIDTH-1:0]});
    if (!keep) bus.in_valid = 1'b0;
    check("run_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  // Wait for out_valid, check latency, then compare against the scoreboard head.
  task automatic wait_result(input string tag);
    int n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < LIMIT) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(cyc - accept_cyc), 32'(WIDTH));
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"}, 32'(bus.sum), 32'(e.s));
      check({tag, "_carry"}, 32'(bus.carry_out), 32'(e.c));
    end
  endtask

  task automatic finish_out(input string tag);
    tick();
    check_idle(tag);
  endtask

  initial begin
    int stall_cyc;
    logic [WIDTH-1:0] held;
    total = 0;
    bad = 0;
    cyc = 0;
    accept_cyc = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_sum", 32'(bus.sum), 32'd0);
    check("reset_carry", 32'(bus.carry_out), 32'd0);

    bus.out_ready = 1'b1;
    accept(8'h3C, 8'h5A, 1'b0);
    wait_result("basic");
    finish_out("basic_ret");

    accept(8'hFF, 8'h01, 1'b0);
    wait_result("wrap");
    finish_out("wrap_ret");
    accept(8'h80, 8'h80, 1'b0);
    wait_result("msb");
    finish_out("msb_ret");

    // Backpressure: result must stay frozen while out_ready is low.
    bus.out_ready = 1'b0;
    accept(8'h12, 8'h34, 1'b0);
    wait_result("stall");
    held = 8'h12 + 8'h34;
    stall_cyc = 0;
    while (stall_cyc < 5) begin
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_sum", 32'(bus.sum), 32'(held));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      stall_cyc++;
    end
    bus.out_ready = 1'b1;
    finish_out("stall_ret");

    // Reset in the middle of RUN abandons the operation.
    accept(8'hAA, 8'h55, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check_idle("abort");
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_carry", 32'(bus.carry_out), 32'd0);
    accept(8'h01, 8'h01, 1'b0);
    wait_result("post_abort");
    finish_out("post_abort_ret");

    // Operands offered during RUN must be ignored.
    accept(8'h0F, 8'hF0, 1'b0);
    bus.in_valid = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    tick();
    check("ignore_in_ready", 32'(bus.in_ready), 32'd0);
    wait_result("ignore");
    bus.in_valid = 1'b0;
    finish_out("ignore_ret");

    // Streaming with in_valid held high: accepts every WIDTH+2 cycles.
    accept(8'h01, 8'h02, 1'b1);
    stall_cyc = accept_cyc;
    bus.a = 8'h7F;
    bus.b = 8'h01;
    wait_result("stream0");
    tick();
    check("stream_gap_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("stream_accept2", 32'(bus.in_ready), 32'd0);
    accept_cyc = cyc;
    check("stream_spacing", 32'(accept_cyc - stall_cyc), 32'(WIDTH + 2));
    sb.push_back(exp_t'{c: 1'b0, s: 8'h80});
    bus.in_valid = 1'b0;
    wait_result("stream1");
    finish_out("stream_ret");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Sequencer that wraps a 1-bit serial full-adder datapath behind parallel valid/ready interfaces. Accepts two WIDTH-bit operands, feeds them LSB-first through the bit cell over WIDTH cycles, reassembles the sum, and presents it with the final carry. Sits between a parallel producer and consumer where area matters more than throughput.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept operands
a  input  WIDTH  operand A, sampled on input handshake
b  input  WIDTH  operand B, sampled on input handshake
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b modulo 2^WIDTH
carry_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: state IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0, bit counter=0, carry register=0. Reset has priority over all other events and aborts any operation in progress. Operands and partial sum are discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1, capture a and b into shift registers, clear the carry register and counter, and go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge processes the current LSBs:
    - bit_sum = a0^b0^c; c_next = (a0&b0)|(c&(a0^b0)).
    - Shift bit_sum into the sum register MSB-first, so after WIDTH shifts bit 0 sits at sum[0].
    - Shift the operand registers right and increment the counter.
    - On the edge where counter==WIDTH-1, latch c_next into carry_out and go to DONE.
  - DONE: out_valid=1, and sum and carry_out hold stable. On an edge with out_ready=1, go to IDLE. In IDLE, sum and carry_out keep their last values.
- Latency: if operands are accepted on edge E, out_valid is first high after edge E+WIDTH. The minimum period between accepts is WIDTH+2 cycles.
- in_valid while in RUN or DONE is ignored, and operands are not re-sampled.
- Backpressure: out_valid stays high and outputs stay frozen for any number of cycles with out_ready=0.
- out_ready=1 while not in DONE has no effect.
- Arithmetic: unsigned, modulo 2^WIDTH. Overflow is reported only through carry_out.
- Datapath logic uses only ^, &, |, ~. No + operator.

Decomposition:
- Shared package serial_add_pkg:
  - enum typedef state_t {IDLE, RUN, DONE}.
  - Function for counter width, $clog2(WIDTH).
- Sub-module serial_add_bit_cell:
  - Ports: clk, rst, clear, en, a, b, sum, carry.
  - Combinational full adder (XOR/AND/OR only) plus a registered carry.
  - clear zeroes the carry; en advances it.
- serial_add_sequencer contains the FSM, counter, operand and sum shift registers, and handshakes.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h5A, out_ready=1 → out_valid 8 edges after accept; sum=8'h96, carry_out=0; in_ready high again the cycle after the output handshake.
- a=8'hFF, b=8'h01 → sum=8'h00, carry_out=1. Then a=8'h80, b=8'h80 → sum=8'h00, carry_out=1. Confirms the carry is cleared between operations.
- a=8'h12, b=8'h34 with out_ready=0 for 5 cycles after out_valid → sum=8'h46 held stable, in_ready=0 throughout. out_ready=1 → IDLE next cycle.
- Accept a=8'hAA, b=8'h55, assert rst after 3 RUN cycles → next cycle IDLE, in_ready=1, out_valid=0, sum=0, carry_out=0. A new operation with a=8'h01, b=8'h01 gives sum=8'h02.
- During RUN, drive in_valid=1 with a=8'hFF, b=8'hFF → ignored; the original a=8'h0F, b=8'hF0 yields sum=8'hFF, carry_out=0.
- Back-to-back: in_valid held high with streamed pairs (8'h01,8'h02), (8'h7F,8'h01) → results 8'h03 then 8'h80, accepts spaced exactly 10 cycles apart with out_ready=1.
